// File: rtl/conf_mul_rr_sched.sv
// Round-robin scheduler sharing one approximate/accurate 32-bit multiplier datapath.
// Holds operands for a mode-dependent cycle count, then returns the product with its requester ID.
module conf_mul_rr_sched #(
    parameter int NUM_REQ            = 4,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int APX_CYCLES         = 1,
    parameter int ACC_CYCLES         = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*32-1:0]         req_a,
    input  logic [NUM_REQ*32-1:0]         req_b,
    input  logic [NUM_REQ-1:0]            req_acc,
    output logic [DATA_PATH_BITWIDTH-1:0] mul_apx_a,
    output logic [DATA_PATH_BITWIDTH-1:0] mul_apx_b,
    output logic [31:0]                   mul_acc_a,
    output logic [31:0]                   mul_acc_b,
    output logic                          mul_acc_sel,
    input  logic [63:0]                   mul_d,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [63:0]                   resp_d,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic                          resp_acc,
    output logic                          busy
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int MAXC = (ACC_CYCLES > APX_CYCLES) ? ACC_CYCLES : APX_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]  APX_LD   = CW'(APX_CYCLES - 1);
    localparam logic [CW-1:0]  ACC_LD   = CW'(ACC_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [IDW-1:0]   r_last;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_acc;
    logic             r_resp_valid;
    logic [63:0]      r_resp_d;
    logic [IDW-1:0]   r_resp_id;
    logic             r_resp_acc;
    logic             r_busy;

    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    logic [IDW:0]     w_idx;
    logic             w_take;

    // Search starts one past the last grant and wraps, so the previous winner ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_last} + (IDW+1)'(k);
            if (w_idx >= NREQ_W)
                w_idx = w_idx - NREQ_W;
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    // Gated by rst as well so every output reads 0 while reset is held.
    assign w_take    = (r_state == S_IDLE) && w_found && rst;
    assign req_ready = w_take ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found)       w_next = S_EXEC;
            S_EXEC:  if (r_cnt == '0)   w_next = S_RESP;
            S_RESP:  if (resp_ready)    w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // Operand registers double as the datapath drive; they are cleared on leaving EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last       <= LAST_RST;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_d     <= '0;
            r_resp_id    <= '0;
            r_resp_acc   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a    <= req_a[{w_gnt, 5'b0} +: 32];
                        r_b    <= req_b[{w_gnt, 5'b0} +: 32];
                        r_acc  <= req_acc[w_gnt];
                        r_last <= w_gnt;
                        r_cnt  <= req_acc[w_gnt] ? ACC_LD : APX_LD;
                        r_busy <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_resp_d     <= mul_d;
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_last;
                        r_resp_acc   <= r_acc;
                        r_a          <= '0;
                        r_b          <= '0;
                        r_acc        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_acc_a   = r_a;
    assign mul_acc_b   = r_b;
    assign mul_apx_a   = r_a[31 -: DATA_PATH_BITWIDTH];
    assign mul_apx_b   = r_b[31 -: DATA_PATH_BITWIDTH];
    assign mul_acc_sel = r_acc;

    assign resp_valid  = r_resp_valid;
    assign resp_d      = r_resp_d;
    assign resp_id     = r_resp_id;
    assign resp_acc    = r_resp_acc;
    assign busy        = r_busy;

endmodule

// File: tb/tb_conf_mul_rr_sched.sv
// Directed bench for conf_mul_rr_sched with a behavioural multiplier datapath model.
module tb_conf_mul_rr_sched;

    localparam int N   = 4;
    localparam int DPW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_acc;
    logic [DPW-1:0]    mul_apx_a;
    logic [DPW-1:0]    mul_apx_b;
    logic [31:0]       mul_acc_a;
    logic [31:0]       mul_acc_b;
    logic              mul_acc_sel;
    logic [63:0]       mul_d;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_d;
    logic [1:0]        resp_id;
    logic              resp_acc;
    logic              busy;

    int vecs = 0;
    int errs = 0;

    conf_mul_rr_sched #(
        .NUM_REQ(N), .DATA_PATH_BITWIDTH(DPW), .APX_CYCLES(1), .ACC_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
        .mul_apx_a(mul_apx_a), .mul_apx_b(mul_apx_b),
        .mul_acc_a(mul_acc_a), .mul_acc_b(mul_acc_b),
        .mul_acc_sel(mul_acc_sel), .mul_d(mul_d),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_d(resp_d), .resp_id(resp_id), .resp_acc(resp_acc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared datapath: full product when accurate, truncated product shifted back up otherwise.
    assign mul_d = mul_acc_sel ? ({32'h0, mul_acc_a} * {32'h0, mul_acc_b})
                               : (({48'h0, mul_apx_a} * {48'h0, mul_apx_b}) << (2*(32-DPW)));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic acc);
        req_valid[i]        = v;
        req_a[i*32 +: 32]   = a;
        req_b[i*32 +: 32]   = b;
        req_acc[i]          = acc;
    endtask

    logic [63:0] fexp [4];
    logic [1:0]  ids  [6];
    logic [63:0] ds   [6];
    int          selcnt, first, got;
    logic [63:0] cap_d;
    logic [1:0]  cap_id;
    logic        cap_acc;

    initial begin
        fexp = '{64'h0000000200000000, 64'h0000000600000000,
                 64'h0000000C00000000, 64'h0000001400000000};
        req_valid = '0; req_a = '0; req_b = '0; req_acc = '0;
        resp_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", mul_acc_sel, 0);
        chk("rst_resp_d", resp_d, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b1;

        // Single approximate op from requester 2
        set_req(2, 1'b1, 32'h00030000, 32'h00050000, 1'b0);
        #1 chk("apx_ready_T", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("apx_a_T1", mul_apx_a, 16'h0003);
        chk("apx_b_T1", mul_apx_b, 16'h0005);
        chk("apx_sel_T1", mul_acc_sel, 0);
        chk("apx_busy_T1", busy, 1);
        chk("apx_nvalid_T1", resp_valid, 0);
        chk("apx_ready_T1", req_ready, 0);
        @(negedge clk);
        chk("apx_valid_T2", resp_valid, 1);
        chk("apx_id_T2", resp_id, 2);
        chk("apx_acc_T2", resp_acc, 0);
        chk("apx_d_T2", resp_d, 64'h0000000F00000000);
        chk("apx_mulidle_T2", mul_apx_a, 0);
        @(negedge clk);
        chk("apx_valid_T3", resp_valid, 0);
        chk("apx_busy_T3", busy, 0);

        // Single accurate op from requester 0
        set_req(0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        #1 chk("acc_ready_T", req_ready, 4'b0001);
        selcnt = 0; first = 0; cap_d = '0; cap_id = '0; cap_acc = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = '0;
                chk("acc_opa_T1", mul_acc_a, 32'h12345678);
            end
            if (mul_acc_sel) selcnt++;
            if (resp_valid && first == 0) begin
                first = k; cap_d = resp_d; cap_id = resp_id; cap_acc = resp_acc;
            end
        end
        chk("acc_sel_cycles", selcnt, 3);
        chk("acc_resp_cycle", first, 4);
        chk("acc_d", cap_d, 64'h0B00EA4E242D2080);
        chk("acc_id", cap_id, 0);
        chk("acc_acc", cap_acc, 1);

        // Round-robin fairness from a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, (i+1) << 16, (i+2) << 16, 1'b0);
        for (int k = 0; k < 6; k++) begin ids[k] = 'x; ds[k] = 'x; end
        got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            chk("fair_onehot", ($countones(req_ready) <= 1), 1);
            if (resp_valid) begin
                ids[got] = resp_id; ds[got] = resp_d; got++;
            end
            if (got == 6) break;
            @(negedge clk);
        end
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            chk("fair_id", ids[k], k % 4);
            chk("fair_d", ds[k], fexp[k % 4]);
        end
        repeat (4) @(negedge clk);

        // Backpressure on requester 3's response while requester 1 waits
        resp_ready = 1'b0;
        set_req(3, 1'b1, 32'h00070000, 32'h00090000, 1'b0);
        #1 chk("bp_ready3", req_ready, 4'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        set_req(1, 1'b1, 32'h00020000, 32'h00040000, 1'b0);
        #1 chk("bp_ready_exec", req_ready, 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", resp_valid, 1);
            chk("bp_id", resp_id, 3);
            chk("bp_d", resp_d, 64'h0000003F00000000);
            chk("bp_ready_hold", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1 chk("bp_ready_hs", req_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_valid_after", resp_valid, 0);
        chk("bp_ready1", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        chk("bp_busy1", busy, 1);
        chk("bp_opa1", mul_apx_a, 16'h0002);
        @(negedge clk);
        chk("bp_id1", resp_id, 1);
        chk("bp_d1", resp_d, 64'h0000000800000000);
        repeat (2) @(negedge clk);

        // Reset during the second EXEC cycle of an accurate op
        set_req(0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        #1 chk("mr_ready0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("mr_sel_pre", mul_acc_sel, 1);
        rst = 1'b0;
        #1;
        chk("mr_sel", mul_acc_sel, 0);
        chk("mr_opa", mul_acc_a, 0);
        chk("mr_apx", mul_apx_a, 0);
        chk("mr_busy", busy, 0);
        chk("mr_valid", resp_valid, 0);
        chk("mr_resp_d", resp_d, 0);
        chk("mr_resp_id", resp_id, 0);
        set_req(0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        set_req(3, 1'b1, 32'h00010000, 32'h00010000, 1'b0);
        #1 chk("mr_ready_in_rst", req_ready, 0);
        @(negedge clk);
        chk("mr_noresp", resp_valid, 0);
        rst = 1'b1;
        #1 chk("mr_prio0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_resp_valid", resp_valid, 1);
        chk("mr_resp_id0", resp_id, 0);
        chk("mr_resp_d0", resp_d, 64'h0B00EA4E242D2080);
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/conf_mul_rr_sched.md
# conf_mul_rr_sched

Round-robin scheduler that shares one configurable 32-bit multiplier datapath (truncated approximate path plus accurate path, selected by `mul_acc_sel`) among `NUM_REQ` requesters. Each request carries its own accuracy mode. The scheduler drives the shared datapath's operands and select lines for a mode-dependent number of cycles, captures the product and returns it with the requester ID over a valid/ready response channel. It sits between the PE request ports and the no-flop multiplier wrapper; it supplies all sequencing and registering that the wrapper lacks.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_PATH_BITWIDTH`, 16: approximate-path operand width (1..32).
- `APX_CYCLES`, 1: cycles operands are held for an approximate op (≥1).
- `ACC_CYCLES`, 3: cycles operands are held for an accurate op (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`, `req_b`  in  NUM_REQ*32 each  flattened 32-bit operands; requester i at bits [32i+31:32i].
- `req_acc`  in  NUM_REQ  per-requester accuracy mode (1 = accurate).
- `mul_apx_a`, `mul_apx_b`  out  DATA_PATH_BITWIDTH  approximate-path operands.
- `mul_acc_a`, `mul_acc_b`  out  32  accurate-path operands.
- `mul_acc_sel`  out  1  datapath result select.
- `mul_d`  in  64  datapath product.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_d`  out  64  captured product.
- `resp_id`  out  $clog2(NUM_REQ)  index of the served requester.
- `resp_acc`  out  1  mode used for this response.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- **States:** IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is set, grant g by round-robin, searching from `last_grant+1` upward with wrap.
  - `req_ready[g]` = 1 combinationally in this cycle. This is the only cycle `req_ready` can be high.
  - At the clock edge: latch `req_a[g]`, `req_b[g]`, `req_acc[g]` and g; set `last_grant` = g; load `cnt` = (acc ? ACC_CYCLES : APX_CYCLES) − 1; go to EXEC.
- **EXEC**
  - Outputs driven from the latched registers: `mul_acc_a`/`mul_acc_b` = full operands; `mul_apx_a`/`mul_apx_b` = operand bits [31:32−DATA_PATH_BITWIDTH]; `mul_acc_sel` = latched acc.
  - Each cycle `cnt` decrements.
  - When `cnt` == 0: capture `mul_d` into `resp_d` at the edge, set `resp_valid`, go to RESP.
- **RESP**
  - `resp_valid`, `resp_d`, `resp_id` and `resp_acc` are held stable until `resp_ready`.
  - On handshake: clear `resp_valid`, go to IDLE.
- **Outputs outside EXEC**
  - All `mul_*` outputs are 0 in IDLE and RESP. This minimises datapath toggling.
- **Widths**
  - No arithmetic in the block; `mul_d` is passed through unmodified.
  - In approximate mode the low 2*(32−DATA_PATH_BITWIDTH) bits are 0, as supplied by the datapath.
- **Requests arriving while busy**
  - Requesters keep `req_valid` asserted; they are not accepted and see no `req_ready` until IDLE.
  - Changes to `req_*` while not granted have no effect.
- **Fairness**
  - With all requesters continuously valid, grant order is 0,1,…,NUM_REQ−1,0,…
- **Reset** (async assert, any state)
  - State → IDLE; `last_grant` = NUM_REQ−1, so requester 0 wins first.
  - `cnt`, operand registers, `resp_d`, `resp_id` and `resp_acc` → 0; `resp_valid`, `busy` and `mul_acc_sel` → 0.
  - An in-flight transaction is dropped without a response.

## Timing
- Accept in cycle T; EXEC occupies T+1 … T+N, where N = APX_CYCLES or ACC_CYCLES.
- `resp_valid` first high in cycle T+N+1.
- Defaults: approximate response at T+2, accurate response at T+4.
- Minimum issue interval is N+2 cycles: the earliest next accept is the cycle after the `resp_ready` handshake.
- `mul_d` is sampled only at the last EXEC edge. The datapath paths must meet N cycles (multicycle constraint = N).
- `req_ready` is combinational from `req_valid` and state; `resp_valid` and `mul_*` are registered.
- `busy` is registered: high from T+1 until the cycle after the response handshake.

## Test plan
- **Single approximate op, DATA_PATH_BITWIDTH = 16**
  - Stimulus: requester 2 sends a = 0x00030000, b = 0x00050000, acc = 0.
  - Required: `req_ready[2]` at T; `mul_apx_a` = 0x0003 and `mul_acc_sel` = 0 at T+1; `resp_valid` at T+2 with `resp_id` = 2, `resp_acc` = 0, `resp_d` = 0x0000000F00000000.
- **Single accurate op**
  - Stimulus: requester 0 sends a = 0x12345678, b = 0x9ABCDEF0, acc = 1.
  - Required: `mul_acc_sel` = 1 for exactly 3 cycles; `resp_valid` at T+4 with `resp_d` = 0x0B00EA4E242D2080.
- **Round-robin fairness**
  - Stimulus: all 4 requesters continuously valid; `resp_ready` tied high.
  - Required: `resp_id` sequence is 0,1,2,3,0,1; no two `req_ready` bits high at once.
- **Backpressure**
  - Stimulus: hold `resp_ready` = 0 for 5 cycles while requester 1 is valid.
  - Required: response fields stay constant; `req_ready` stays 0; requester 1 is accepted the cycle after the handshake.
- **Mid-operation reset**
  - Stimulus: assert `rst` = 0 during the second EXEC cycle of an accurate op.
  - Required: all outputs are 0 asynchronously; no response; after release, requester 0 has priority over requester 3.
